// File: rtl/aes_multiblock_fsm.sv
// aes_multiblock_fsm
//   Controller for a multi-block AES job. It latches the job configuration on
//   start. For each block it then sequences a source load, an engine compute
//   and a sink store. At the end it pulses done_o.
//
//   Ports:
//     clk, reset, clear           clock; synchronous active-high reset and soft clear
//     start_i                     job start pulse (ignored while busy)
//     n_blocks_i, src_base_i,
//     dst_base_i, mode_i          job configuration, latched on start
//     src_req_start_o/src_addr_o  source request and its block address
//     src_ready_start_i/src_done_i
//     snk_req_start_o/snk_addr_o  sink request and its block address
//     snk_ready_start_i/snk_done_i
//     eng_clear_o/eng_start_o/eng_enable_o/eng_decrypt_o/eng_chain_o, eng_done_i
//     busy_o, done_o, blk_cnt_o   status
module aes_multiblock_fsm #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_blocks_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [1:0]        mode_i,
  output logic              src_req_start_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic              src_ready_start_i,
  input  logic              src_done_i,
  output logic              snk_req_start_o,
  output logic [ADDR_W-1:0] snk_addr_o,
  input  logic              snk_ready_start_i,
  input  logic              snk_done_i,
  output logic              eng_clear_o,
  output logic              eng_start_o,
  output logic              eng_enable_o,
  output logic              eng_decrypt_o,
  output logic              eng_chain_o,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STARTING,
    S_REQ_SRC,
    S_LOAD,
    S_COMPUTE,
    S_REQ_SNK,
    S_STORE,
    S_FINISHED
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  blk_cnt_q;
  logic [CNT_W-1:0]  n_blocks_q;
  logic [ADDR_W-1:0] src_base_q;
  logic [ADDR_W-1:0] dst_base_q;
  logic [1:0]        mode_q;
  logic              last_blk;
  logic [ADDR_W-1:0] blk_off;

  // Only evaluated in STORE, where n_blocks_q >= 1, so the subtraction cannot wrap.
  assign last_blk = (blk_cnt_q == (n_blocks_q - CNT_W'(1)));

  // Modulo 2^ADDR_W offset; BLOCK_BYTES need not be a power of two.
  assign blk_off  = ADDR_W'(blk_cnt_q) * ADDR_W'(BLOCK_BYTES);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= S_IDLE;
      blk_cnt_q  <= '0;
      n_blocks_q <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      mode_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        n_blocks_q <= n_blocks_i;
        src_base_q <= src_base_i;
        dst_base_q <= dst_base_i;
        mode_q     <= mode_i;
        blk_cnt_q  <= '0;
      end
      if (state_q == S_STORE && snk_done_i && !last_blk) begin
        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    src_req_start_o = 1'b0;
    snk_req_start_o = 1'b0;
    eng_clear_o     = 1'b0;
    eng_start_o     = 1'b0;
    eng_enable_o    = 1'b0;
    done_o          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        eng_clear_o = 1'b1;
        if (start_i) state_d = S_STARTING;
      end
      S_STARTING: begin
        eng_start_o = 1'b1;
        state_d     = (n_blocks_q == '0) ? S_FINISHED : S_REQ_SRC;
      end
      S_REQ_SRC: begin
        src_req_start_o = 1'b1;
        if (src_ready_start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (src_done_i) begin
          eng_enable_o = 1'b1;
          state_d      = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (eng_done_i) state_d = S_REQ_SNK;
      end
      S_REQ_SNK: begin
        snk_req_start_o = 1'b1;
        if (snk_ready_start_i) state_d = S_STORE;
      end
      S_STORE: begin
        if (snk_done_i) state_d = last_blk ? S_FINISHED : S_REQ_SRC;
      end
      S_FINISHED: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o        = (state_q != S_IDLE);
  assign src_addr_o    = src_base_q + blk_off;
  assign snk_addr_o    = dst_base_q + blk_off;
  assign blk_cnt_o     = blk_cnt_q;
  assign eng_decrypt_o = busy_o && mode_q[0];
  assign eng_chain_o   = busy_o && mode_q[1] && (blk_cnt_q != '0);

endmodule

// File: tb/tb_aes_multiblock_fsm.sv
module tb_aes_multiblock_fsm;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BB     = 16;

  logic              clk = 1'b0;
  logic              reset, clear, start_i;
  logic [CNT_W-1:0]  n_blocks_i;
  logic [ADDR_W-1:0] src_base_i, dst_base_i;
  logic [1:0]        mode_i;
  logic              src_req_start_o, src_ready_start_i, src_done_i;
  logic [ADDR_W-1:0] src_addr_o, snk_addr_o;
  logic              snk_req_start_o, snk_ready_start_i, snk_done_i;
  logic              eng_clear_o, eng_start_o, eng_enable_o, eng_decrypt_o, eng_chain_o, eng_done_i;
  logic              busy_o, done_o;
  logic [CNT_W-1:0]  blk_cnt_o;

  aes_multiblock_fsm #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .BLOCK_BYTES(BB)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i), .mode_i(mode_i),
    .src_req_start_o(src_req_start_o), .src_addr_o(src_addr_o),
    .src_ready_start_i(src_ready_start_i), .src_done_i(src_done_i),
    .snk_req_start_o(snk_req_start_o), .snk_addr_o(snk_addr_o),
    .snk_ready_start_i(snk_ready_start_i), .snk_done_i(snk_done_i),
    .eng_clear_o(eng_clear_o), .eng_start_o(eng_start_o), .eng_enable_o(eng_enable_o),
    .eng_decrypt_o(eng_decrypt_o), .eng_chain_o(eng_chain_o), .eng_done_i(eng_done_i),
    .busy_o(busy_o), .done_o(done_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int chks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference address rule: base + block * BLOCK_BYTES, modulo 2^32.
  function automatic logic [31:0] addr_of(input logic [31:0] base, input int blk);
    logic [63:0] full;
    full = 64'(base) + 64'(blk) * 64'(BB);
    return full[31:0];
  endfunction

  task automatic clr_pulses();
    src_ready_start_i = 1'b0; src_done_i = 1'b0;
    snk_ready_start_i = 1'b0; snk_done_i = 1'b0;
    eng_done_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int exp_blk);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_eng_clear"}, eng_clear_o, 1);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_blk"}, blk_cnt_o, exp_blk);
    chk({tag, "_dec"}, eng_decrypt_o, 0);
    chk({tag, "_chain"}, eng_chain_o, 0);
    chk({tag, "_reqs"}, {src_req_start_o, snk_req_start_o, eng_start_o, eng_enable_o}, 0);
  endtask

  // Environment plus reference model. Phases: 0 await src grant, 1 loading,
  // 2 computing, 3 await snk grant, 4 storing, 5 job finished.
  // abort_kind: 0 none, 1 clear, 2 reset, applied during COMPUTE of abort_blk.
  task automatic run_job(input int n, input logic [31:0] sb, input logic [31:0] db,
                         input logic [1:0] md, input int lat, input int stall, input bit spur,
                         input int abort_blk, input int abort_kind,
                         output logic [31:0] last_src, output int final_blk);
    int ph, blk, cur, timer, cyc, req_cycles, en_cycles, done_cycles;
    bit fin, give;
    last_src = '0; final_blk = -1;
    ph = (n == 0) ? 5 : 0;
    blk = 0; timer = 0; cyc = 0; req_cycles = 0; en_cycles = 0; done_cycles = 0; fin = 0;

    @(negedge clk);
    clr_pulses();
    start_i = 1'b1; n_blocks_i = CNT_W'(n); src_base_i = sb; dst_base_i = db; mode_i = md;
    #1 chk("pre_start_clear", eng_clear_o, 1);
    chk("pre_start_busy", busy_o, 0);
    @(negedge clk);
    start_i = 1'b0;
    n_blocks_i = CNT_W'($urandom); src_base_i = $urandom; dst_base_i = $urandom; mode_i = 2'($urandom);
    #1 chk("eng_start", eng_start_o, 1);
    chk("starting_busy", busy_o, 1);
    chk("starting_blk", blk_cnt_o, 0);

    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      clr_pulses();
      give = 0;
      cur = (n == 0) ? 0 : ((blk < n) ? blk : n - 1);
      if (abort_kind != 0 && ph == 2 && blk == abort_blk) begin
        if (abort_kind == 1) clear = 1'b1; else reset = 1'b1;
        eng_done_i = 1'b1;
        @(negedge clk);
        clear = 1'b0; reset = 1'b0; eng_done_i = 1'b0;
        #1 check_idle("abort", 0);
        chk("abort_src_addr", src_addr_o, 0);
        chk("abort_snk_addr", snk_addr_o, 0);
        @(negedge clk);
        #1 chk("abort_no_done", done_o, 0);
        chk("abort_stay_idle", busy_o, 0);
        return;
      end
      case (ph)
        0: begin give = (timer >= stall); src_ready_start_i = give; end
        1: begin
          if (timer >= lat) begin give = 1; src_done_i = 1'b1; end
          else if (spur) begin start_i = 1'b1; snk_done_i = 1'b1; snk_ready_start_i = 1'b1; eng_done_i = 1'b1; end
        end
        2: begin give = (timer >= lat); eng_done_i = give; end
        3: begin give = (timer >= lat); snk_ready_start_i = give; end
        4: begin give = (timer >= lat); snk_done_i = give; end
        default: ;
      endcase
      #1;
      chk("busy", busy_o, 1);
      chk("src_req", src_req_start_o, (ph == 0));
      chk("snk_req", snk_req_start_o, (ph == 3));
      chk("eng_enable", eng_enable_o, (ph == 1 && give));
      chk("done", done_o, (ph == 5));
      chk("eng_start_low", eng_start_o, 0);
      chk("eng_clear_low", eng_clear_o, 0);
      chk("blk_cnt", blk_cnt_o, cur);
      chk("src_addr", src_addr_o, addr_of(sb, cur));
      chk("snk_addr", snk_addr_o, addr_of(db, cur));
      chk("decrypt", eng_decrypt_o, md[0]);
      chk("chain", eng_chain_o, (md[1] && cur != 0));
      if (src_req_start_o) begin req_cycles++; last_src = src_addr_o; end
      if (eng_enable_o) en_cycles++;
      if (done_o) done_cycles++;
      if (ph == 5) fin = 1;
      else if (give) begin
        timer = 0;
        if (ph == 4) begin blk++; ph = (blk == n) ? 5 : 0; end
        else ph++;
      end else timer++;
    end
    chk("job_timeout", fin, 1);
    @(negedge clk);
    clr_pulses();
    #1 check_idle("post_job", (n == 0) ? 0 : n - 1);
    final_blk = int'(blk_cnt_o);
    chk("enable_pulses", en_cycles, n);
    chk("done_pulses", done_cycles, 1);
    chk("src_req_cycles", req_cycles, n * (stall + 1));
  endtask

  typedef struct {
    int          n;
    logic [31:0] sb, db;
    logic [1:0]  md;
    int          lat, stall;
    bit          spur;
    logic [31:0] exp_last_src;
    int          exp_final;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] ls;
    int fb;
    vecs[0] = '{1, 32'h1000, 32'h2000, 2'b00, 1, 0, 0, 32'h1000, 0};
    vecs[1] = '{4, 32'h0100, 32'h0800, 2'b11, 1, 0, 0, 32'h0130, 3};
    vecs[2] = '{0, 32'h0040, 32'h0080, 2'b10, 0, 0, 0, 32'h0000, 0};
    vecs[3] = '{2, 32'hFFFFFFF0, 32'h0010, 2'b00, 0, 0, 0, 32'h0000_0000, 1};
    vecs[4] = '{3, 32'h0500, 32'h0600, 2'b01, 2, 9, 1, 32'h0520, 2};
    vecs[5] = '{5, 32'hFFFFFFE0, 32'hFFFFFFF0, 2'b10, 0, 1, 1, 32'h0000_0020, 4};

    reset = 1'b1; clear = 1'b0; clr_pulses();
    n_blocks_i = '0; src_base_i = '0; dst_base_i = '0; mode_i = '0;
    repeat (3) @(negedge clk);
    #1 check_idle("reset", 0);
    chk("reset_src_addr", src_addr_o, 0);
    chk("reset_snk_addr", snk_addr_o, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].n, vecs[i].sb, vecs[i].db, vecs[i].md, vecs[i].lat, vecs[i].stall,
              vecs[i].spur, 0, 0, ls, fb);
      chk("vec_last_src", ls, vecs[i].exp_last_src);
      chk("vec_final_blk", fb, vecs[i].exp_final);
    end

    // Abort by clear during COMPUTE of block 2, then a clean job.
    run_job(4, 32'h3000, 32'h4000, 2'b10, 1, 0, 0, 2, 1, ls, fb);
    run_job(2, 32'h3000, 32'h4000, 2'b10, 0, 0, 0, 0, 0, ls, fb);
    chk("after_clear_last_src", ls, 32'h3010);
    // Same with reset.
    run_job(4, 32'h5000, 32'h6000, 2'b11, 0, 0, 0, 2, 2, ls, fb);
    run_job(1, 32'h7000, 32'h8000, 2'b01, 0, 0, 0, 0, 0, ls, fb);
    chk("after_reset_last_src", ls, 32'h7000);

    for (int i = 0; i < 14; i++) begin
      int n, lat, stall;
      logic [31:0] sb, db;
      n = int'($urandom_range(0, 5));
      lat = int'($urandom_range(0, 2));
      stall = int'($urandom_range(0, 2));
      sb = $urandom; db = $urandom;
      run_job(n, sb, db, 2'($urandom), lat, stall, 1'($urandom), 0, 0, ls, fb);
      chk("rnd_last_src", ls, (n == 0) ? 32'h0 : addr_of(sb, n - 1));
      chk("rnd_final_blk", fb, (n == 0) ? 0 : n - 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
